// File: rtl/vram_scan_scheduler.sv
// Pixel-domain VRAM read scheduler: maps VGA coordinates onto a 4x-upscaled, centred
// handheld frame and swaps the display/capture frame-buffer banks only at frame start.
module vram_scan_scheduler #(
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 144,
  parameter int SCALE      = 4,
  parameter int X_OFFSET   = 320,
  parameter int Y_OFFSET   = 72,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clkPixel,
  input  logic                  i_resetN,
  input  logic                  i_active,
  input  logic [15:0]           i_x,
  input  logic [15:0]           i_y,
  input  logic                  i_frameDone,
  output logic [ADDR_WIDTH-1:0] o_readAddr,
  output logic                  o_inWindow,
  output logic                  o_readBank,
  output logic                  o_writeBank,
  output logic                  o_swapPending,
  output logic [7:0]            o_dropCount
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  localparam logic [15:0] X_FIRST = 16'(X_OFFSET);
  localparam logic [15:0] X_END   = 16'(X_OFFSET + SRC_W * SCALE);
  localparam logic [15:0] X_LAST  = 16'(X_OFFSET + SRC_W * SCALE - 1);
  localparam logic [15:0] Y_FIRST = 16'(Y_OFFSET);
  localparam logic [15:0] Y_END   = 16'(Y_OFFSET + SRC_H * SCALE);

  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(SRC_W * SRC_H);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(SRC_W);
  localparam logic [SUB_W-1:0]      SUB_LAST   = SUB_W'(SCALE - 1);

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_PENDING = 1'b1
  } bank_state_e;

  logic                  r_synced;
  logic [SUB_W-1:0]      r_h_sub;
  logic [COL_W-1:0]      r_col;
  logic [SUB_W-1:0]      r_v_sub;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic                  r_win_d1;
  logic                  r_in_window;
  logic                  r_read_bank;
  logic [7:0]            r_drop_count;
  bank_state_e           r_state;

  bank_state_e           w_next_state;
  logic                  w_swap;
  logic                  w_drop;
  logic                  w_swap_pending;
  logic                  w_fs;
  logic                  w_win;
  logic                  w_last_col;
  logic [ADDR_WIDTH-1:0] w_bank_base;

  assign w_fs = (i_x == 16'd0) && (i_y == 16'd0);

  // Nothing is displayed until a frame start has been seen, so a mid-frame reset blanks.
  assign w_win = i_active && r_synced &&
                 (i_x >= X_FIRST) && (i_x < X_END) &&
                 (i_y >= Y_FIRST) && (i_y < Y_END);

  assign w_last_col  = w_win && (i_x == X_LAST);
  assign w_bank_base = r_read_bank ? BANK1_BASE : '0;

  // Scan counters: the address is built by accumulation so no multiplier is needed.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clkPixel) begin
    if (!i_resetN) begin
      r_synced   <= 1'b0;
      r_h_sub    <= '0;
      r_col      <= '0;
      r_v_sub    <= '0;
      r_row_base <= '0;
    end else if (w_fs) begin
      r_synced   <= 1'b1;
      r_h_sub    <= '0;
      r_col      <= '0;
      r_v_sub    <= '0;
      r_row_base <= '0;
    end else begin
      if (w_win && !w_last_col) begin
        if (r_h_sub == SUB_LAST) begin
          r_h_sub <= '0;
          r_col   <= r_col + 1'b1;
        end else begin
          r_h_sub <= r_h_sub + 1'b1;
        end
      end else begin
        r_h_sub <= '0;
        r_col   <= '0;
      end

      if (w_last_col) begin
        if (r_v_sub == SUB_LAST) begin
          r_v_sub    <= '0;
          r_row_base <= r_row_base + ROW_STEP;
        end else begin
          r_v_sub <= r_v_sub + 1'b1;
        end
      end
    end
  end

  // Two-stage window flag tracks the address register plus the SRAM read cycle.
  always_ff @(posedge i_clkPixel) begin
    if (!i_resetN) begin
      r_read_addr <= '0;
      r_win_d1    <= 1'b0;
      r_in_window <= 1'b0;
    end else begin
      r_read_addr <= w_win ? (w_bank_base + r_row_base + ADDR_WIDTH'(r_col)) : w_bank_base;
      r_win_d1    <= w_win;
      r_in_window <= r_win_d1;
    end
  end

  always_ff @(posedge i_clkPixel) begin
    if (!i_resetN) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A pulse coincident with frame start always belongs to the bank the writer now owns.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_swap       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_READY: begin
        if (i_frameDone && w_fs) begin
          w_swap = 1'b1;
        end else if (i_frameDone) begin
          w_next_state = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_fs) begin
          w_swap = 1'b1;
          if (!i_frameDone) begin
            w_next_state = ST_READY;
          end
        end else if (i_frameDone) begin
          w_drop = 1'b1;
        end
      end
      default: w_next_state = ST_READY;
    endcase
  end

  always_comb begin
    w_swap_pending = (r_state == ST_PENDING);
  end

  always_ff @(posedge i_clkPixel) begin
    if (!i_resetN) begin
      r_read_bank  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_swap) begin
        r_read_bank <= ~r_read_bank;
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign o_readAddr    = r_read_addr;
  assign o_inWindow    = r_in_window;
  assign o_readBank    = r_read_bank;
  assign o_writeBank   = ~r_read_bank;
  assign o_swapPending = w_swap_pending;
  assign o_dropCount   = r_drop_count;

endmodule

// File: tb/tb_vram_scan_scheduler.sv
// Self-checking bench for vram_scan_scheduler: compressed rasters (full lines where
// addresses matter, one-pixel lines elsewhere) against a coordinate-arithmetic model.
module tb_vram_scan_scheduler;

  typedef struct {
    int x;
    int y;
    bit act;
    bit fd;
    bit rstn;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        active;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        frame_done;
  logic [15:0] read_addr;
  logic        in_window;
  logic        read_bank;
  logic        write_bank;
  logic        swap_pending;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int m_bank, m_pend, m_drops, m_synced, m_vcnt, m_run, m_w1, m_w2, exp_addr;

  // Per-frame captures
  int cap_a0, cap_a1, cap_a159, cap_a160, cap_alast, cap_w0, cap_w1;
  int cap_hole_addr, cap_hole_win, cap_after_hole;
  int any_pend, any_win_after_rst;

  always #5 clk = ~clk;

  vram_scan_scheduler dut (
    .i_clkPixel    (clk),
    .i_resetN      (reset_n),
    .i_active      (active),
    .i_x           (x_in),
    .i_y           (y_in),
    .i_frameDone   (frame_done),
    .o_readAddr    (read_addr),
    .o_inWindow    (in_window),
    .o_readBank    (read_bank),
    .o_writeBank   (write_bank),
    .o_swapPending (swap_pending),
    .o_dropCount   (drop_count)
  );

  function automatic stim_t mk(int x, int y, bit act, bit fd, bit rstn);
    stim_t s;
    s.x = x; s.y = y; s.act = act; s.fd = fd; s.rstn = rstn;
    return s;
  endfunction

  // Drive one pixel, wait for the edge to pass, then advance the model.
  task automatic step(input stim_t s);
    int win, fs, base;
    win = (s.rstn && s.act && m_synced != 0 && s.x >= 320 && s.x < 960 &&
           s.y >= 72 && s.y < 648) ? 1 : 0;
    fs = (s.x == 0 && s.y == 0) ? 1 : 0;
    x_in = 16'(s.x); y_in = 16'(s.y);
    active = s.act; frame_done = s.fd; reset_n = s.rstn;
    @(negedge clk);
    if (!s.rstn) begin
      exp_addr = 0; m_bank = 0; m_pend = 0; m_drops = 0; m_synced = 0;
      m_vcnt = 0; m_run = 0; m_w1 = 0; m_w2 = 0;
    end else begin
      base = m_bank * 23040;
      exp_addr = win ? base + (m_vcnt / 4) * 160 + m_run / 4 : base;
      m_w2 = m_w1;
      m_w1 = win;
      if (win && s.x != 959) m_run++;
      else m_run = 0;
      if (win && s.x == 959) m_vcnt++;
      if (fs) begin
        m_synced = 1; m_vcnt = 0; m_run = 0;
      end
      if (fs && (m_pend != 0 || s.fd)) begin
        m_bank = 1 - m_bank;
        m_pend = (m_pend != 0 && s.fd) ? 1 : 0;
      end else if (s.fd) begin
        if (m_pend != 0 && m_drops < 255) m_drops++;
        m_pend = 1;
      end
    end
  endtask

  task automatic run_frame(input int fd_y1, input int fd_y2, input bit fd_fs,
                           input int rst_y, input bit holes);
    stim_t q[$];
    int r1, r2;
    bit full, after_rst, act;
    r1 = $urandom_range(300, 77);
    r2 = $urandom_range(646, 301);
    cap_a0 = -1; cap_a1 = -1; cap_a159 = -1; cap_a160 = -1; cap_alast = -1;
    cap_w0 = -1; cap_w1 = -1; cap_hole_addr = -1; cap_hole_win = -1; cap_after_hole = -1;
    any_pend = 0; any_win_after_rst = 0; after_rst = 0;
    q.push_back(mk(0, 0, 1, fd_fs, 1));
    q.push_back(mk(1, 0, 1, 0, 1));
    q.push_back(mk(2, 0, 1, 0, 1));
    q.push_back(mk(330, 71, 1, 0, 1));
    for (int yy = 72; yy < 648; yy++) begin
      full = (yy == 72 || yy == 73 || yy == 76 || yy == 647 || yy == r1 || yy == r2 ||
              yy == rst_y || (holes && yy == 200));
      if (full) begin
        for (int xx = 320; xx < 960; xx++) begin
          act = 1'b1;
          if (holes && yy == 200 && xx >= 600 && xx < 608) act = 1'b0;
          if (holes && yy == r2 && $urandom_range(7, 0) == 0) act = 1'b0;
          q.push_back(mk(xx, yy, act, 0, !(yy == rst_y && xx == 500)));
        end
      end else begin
        q.push_back(mk(959, yy, 1, 0, 1));
      end
      q.push_back(mk(960, yy, 1, (yy == fd_y1 || yy == fd_y2), 1));
    end
    q.push_back(mk(320, 648, 1, 0, 1));
    q.push_back(mk(959, 650, 1, 0, 1));
    q.push_back(mk(1279, 719, 1, 0, 1));

    foreach (q[i]) begin
      step(q[i]);
      n_chk += 6;
      if (read_addr !== 16'(exp_addr)) begin
        n_fail++;
        $display("FAIL frame_addr at (%0d,%0d): got %0d want %0d", q[i].x, q[i].y, read_addr, exp_addr);
      end
      if (in_window !== (m_w2 != 0)) begin
        n_fail++;
        $display("FAIL frame_in_window at (%0d,%0d): got %b want %0d", q[i].x, q[i].y, in_window, m_w2);
      end
      if (read_bank !== (m_bank != 0)) begin
        n_fail++;
        $display("FAIL frame_read_bank at (%0d,%0d): got %b want %0d", q[i].x, q[i].y, read_bank, m_bank);
      end
      if (write_bank !== (m_bank == 0)) begin
        n_fail++;
        $display("FAIL frame_write_bank at (%0d,%0d): got %b want %0d", q[i].x, q[i].y, write_bank, 1 - m_bank);
      end
      if (swap_pending !== (m_pend != 0)) begin
        n_fail++;
        $display("FAIL frame_swap_pending at (%0d,%0d): got %b want %0d", q[i].x, q[i].y, swap_pending, m_pend);
      end
      if (drop_count !== 8'(m_drops)) begin
        n_fail++;
        $display("FAIL frame_drop_count at (%0d,%0d): got %0d want %0d", q[i].x, q[i].y, drop_count, m_drops);
      end
      if (q[i].x == 320 && q[i].y == 72) begin cap_a0 = read_addr; cap_w0 = in_window; end
      if (q[i].x == 321 && q[i].y == 72) cap_w1 = in_window;
      if (q[i].x == 324 && q[i].y == 72) cap_a1 = read_addr;
      if (q[i].x == 959 && q[i].y == 72) cap_a159 = read_addr;
      if (q[i].x == 320 && q[i].y == 76) cap_a160 = read_addr;
      if (q[i].x == 959 && q[i].y == 647) cap_alast = read_addr;
      if (holes && q[i].y == 200) begin
        if (q[i].x == 604) cap_hole_addr = read_addr;
        if (q[i].x == 602) cap_hole_win = in_window;
        if (q[i].x == 608) cap_after_hole = read_addr;
      end
      if (swap_pending) any_pend = 1;
      if (after_rst && in_window) any_win_after_rst = 1;
      if (!q[i].rstn) after_rst = 1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(mk(100, 100, 1, 1, 0));
    n_chk += 6;
    if (read_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", read_addr); end
    if (in_window !== 1'b0) begin n_fail++; $display("FAIL reset_in_window: got %b want 0", in_window); end
    if (read_bank !== 1'b0) begin n_fail++; $display("FAIL reset_read_bank: got %b want 0", read_bank); end
    if (write_bank !== 1'b1) begin n_fail++; $display("FAIL reset_write_bank: got %b want 1", write_bank); end
    if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_swap_pending: got %b want 0", swap_pending); end
    if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
  endtask

  task automatic test_basic_frame();
    run_frame(-1, -1, 0, -1, 0);
    n_chk += 9;
    if (cap_a0 !== 0) begin n_fail++; $display("FAIL basic_addr_320_72: got %0d want 0", cap_a0); end
    if (cap_a1 !== 1) begin n_fail++; $display("FAIL basic_addr_324_72: got %0d want 1", cap_a1); end
    if (cap_a159 !== 159) begin n_fail++; $display("FAIL basic_addr_959_72: got %0d want 159", cap_a159); end
    if (cap_a160 !== 160) begin n_fail++; $display("FAIL basic_addr_320_76: got %0d want 160", cap_a160); end
    if (cap_alast !== 23039) begin n_fail++; $display("FAIL basic_addr_959_647: got %0d want 23039", cap_alast); end
    if (cap_w0 !== 0) begin n_fail++; $display("FAIL basic_in_window_early: got %0d want 0", cap_w0); end
    if (cap_w1 !== 1) begin n_fail++; $display("FAIL basic_in_window_rise: got %0d want 1", cap_w1); end
    if (read_bank !== 1'b0) begin n_fail++; $display("FAIL basic_read_bank: got %b want 0", read_bank); end
    if (any_pend !== 0) begin n_fail++; $display("FAIL basic_no_pending: got %0d want 0", any_pend); end
  endtask

  task automatic test_swap();
    run_frame(100, -1, 0, -1, 0);
    n_chk += 2;
    if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL swap_pending_held: got %b want 1", swap_pending); end
    if (read_bank !== 1'b0) begin n_fail++; $display("FAIL swap_bank_before_fs: got %b want 0", read_bank); end
  endtask

  task automatic test_drop();
    run_frame(100, 200, 0, -1, 0);
    n_chk += 6;
    if (cap_a0 !== 23040) begin n_fail++; $display("FAIL swap_first_addr: got %0d want 23040", cap_a0); end
    if (cap_alast !== 46079) begin n_fail++; $display("FAIL swap_last_addr: got %0d want 46079", cap_alast); end
    if (read_bank !== 1'b1) begin n_fail++; $display("FAIL swap_read_bank: got %b want 1", read_bank); end
    if (write_bank !== 1'b0) begin n_fail++; $display("FAIL swap_write_bank: got %b want 0", write_bank); end
    if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count_one: got %0d want 1", drop_count); end
    if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL drop_still_pending: got %b want 1", swap_pending); end
    run_frame(-1, -1, 0, -1, 0);
    n_chk += 4;
    if (read_bank !== 1'b0) begin n_fail++; $display("FAIL drop_single_swap_bank: got %b want 0", read_bank); end
    if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL drop_pending_cleared: got %b want 0", swap_pending); end
    if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count_kept: got %0d want 1", drop_count); end
    if (cap_a0 !== 0) begin n_fail++; $display("FAIL drop_frame_first_addr: got %0d want 0", cap_a0); end
  endtask

  task automatic test_fd_at_fs_active_gate();
    run_frame(-1, -1, 1, -1, 1);
    n_chk += 6;
    if (any_pend !== 0) begin n_fail++; $display("FAIL fsfd_pending_seen: got %0d want 0", any_pend); end
    if (read_bank !== 1'b1) begin n_fail++; $display("FAIL fsfd_read_bank: got %b want 1", read_bank); end
    if (cap_a0 !== 23040) begin n_fail++; $display("FAIL fsfd_first_addr: got %0d want 23040", cap_a0); end
    if (cap_hole_addr !== 23040) begin n_fail++; $display("FAIL gate_addr_base: got %0d want 23040", cap_hole_addr); end
    if (cap_hole_win !== 0) begin n_fail++; $display("FAIL gate_in_window: got %0d want 0", cap_hole_win); end
    if (cap_after_hole !== 28160) begin n_fail++; $display("FAIL gate_col_restart: got %0d want 28160", cap_after_hole); end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(-1, -1, 0, 300, 0);
    n_chk += 3;
    if (any_win_after_rst !== 0) begin n_fail++; $display("FAIL midrst_in_window: got %0d want 0", any_win_after_rst); end
    if (read_bank !== 1'b0) begin n_fail++; $display("FAIL midrst_read_bank: got %b want 0", read_bank); end
    if (write_bank !== 1'b1) begin n_fail++; $display("FAIL midrst_write_bank: got %b want 1", write_bank); end
    run_frame(-1, -1, 0, -1, 0);
    n_chk += 3;
    if (cap_a0 !== 0) begin n_fail++; $display("FAIL midrst_next_first: got %0d want 0", cap_a0); end
    if (cap_a160 !== 160) begin n_fail++; $display("FAIL midrst_next_row: got %0d want 160", cap_a160); end
    if (cap_w1 !== 1) begin n_fail++; $display("FAIL midrst_next_in_window: got %0d want 1", cap_w1); end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 300; i++) begin
      step(mk(1000, 700, 1, 1, 1));
      n_chk++;
      if (drop_count !== 8'(m_drops)) begin
        n_fail++;
        $display("FAIL sat_drop_track step %0d: got %0d want %0d", i, drop_count, m_drops);
      end
    end
    n_chk += 2;
    if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_drop_count: got %0d want 255", drop_count); end
    if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL sat_pending: got %b want 1", swap_pending); end
  endtask

  initial begin
    m_bank = 0; m_pend = 0; m_drops = 0; m_synced = 0;
    m_vcnt = 0; m_run = 0; m_w1 = 0; m_w2 = 0; exp_addr = 0;
    test_reset();
    test_basic_frame();
    test_swap();
    test_drop();
    test_fd_at_fs_active_gate();
    test_reset_mid_frame();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_scan_scheduler.md
# vram_scan_scheduler

Pixel-clock-domain controller that sequences read access to the double-banked video frame buffer. It produces the VRAM read address for each VGA pixel, scaling the 160x144 handheld image 4x and centring it in the 1280x720 raster. It also arbitrates the two frame-buffer banks between the capture (writer) side and the display (reader) side, swapping them only at VGA frame start so the displayed image never tears. It sits between the VGA timing controller and the frame-buffer SRAM read port.

## Interface
Parameters:
- SRC_W, 160, source image width in pixels
- SRC_H, 144, source image height in lines
- SCALE, 4, integer upscale factor (both axes); must be ≥1
- X_OFFSET, 320, first displayed VGA column of the window
- Y_OFFSET, 72, first displayed VGA line of the window
- ADDR_WIDTH, 16, VRAM address width; must hold 2*SRC_W*SRC_H-1

Ports:
- i_clkPixel  input  1  pixel clock; all logic is on its rising edge
- i_resetN  input  1  reset, synchronous, active-low
- i_active  input  1  VGA active-video flag from the timing controller
- i_x  input  16  current VGA column
- i_y  input  16  current VGA line
- i_frameDone  input  1  one-cycle pulse meaning the writer has completed a frame into o_writeBank; already synchronised to i_clkPixel
- o_readAddr  output  ADDR_WIDTH  VRAM read address, registered
- o_inWindow  output  1  high when the SRAM data now at the read port belongs to the window; aligned with SRAM output
- o_readBank  output  1  bank currently displayed
- o_writeBank  output  1  bank the writer must fill; always equal to ~o_readBank
- o_swapPending  output  1  a completed frame is waiting for the next frame start
- o_dropCount  output  8  saturating count of frames overwritten before they could be displayed

## Operation
- Window: `win = i_active & synced & (X_OFFSET ≤ i_x < X_OFFSET+SRC_W*SCALE) & (Y_OFFSET ≤ i_y < Y_OFFSET+SRC_H*SCALE)`.
- Frame start (FS) is the cycle in which `i_x==0 && i_y==0`.
  - At FS, `synced` is set to 1.
  - At FS, these are cleared: `rowBase`, `vSub`, `hSub`, `col`.
- Address generation uses no multiplier. The terms are:
  - `bankBase` = o_readBank ? SRC_W*SRC_H : 0
  - `o_readAddr` ← `bankBase + rowBase + col`
- Horizontal counters:
  - Outside `win`, `hSub` and `col` are held at 0.
  - Inside `win`, `hSub` increments every cycle.
  - When `hSub` reaches SCALE-1, `hSub` wraps to 0 and `col` increments.
- Vertical counters:
  - In the cycle `i_x == X_OFFSET+SRC_W*SCALE-1` with `win` high, `vSub` increments.
  - When `vSub` wraps from SCALE-1 to 0, `rowBase += SRC_W`.
- Outside `win`, `o_readAddr` = `bankBase` (defined, don't-care for the pixel).
- Bank FSM has two states, READY and PENDING. `o_swapPending` = (state==PENDING).
  - READY, i_frameDone → PENDING.
  - PENDING, FS → READY. On this transition `o_readBank` toggles and `o_writeBank` toggles.
  - PENDING, i_frameDone (not at FS) → stay in PENDING and increment `o_dropCount` (saturating at 255). The writer overwrites the pending bank.
  - READY with i_frameDone and FS in the same cycle → swap immediately and end in READY. The new frame is shown this frame.
  - PENDING with i_frameDone and FS in the same cycle → swap, stay in PENDING. The new pulse belongs to the bank just handed to the writer, so it is not a drop.
- The bank swap happens only at FS. The window rows never straddle a swap.

## Timing
- Reset (i_resetN low at a clock edge) sets:
  - o_readAddr = 0, o_inWindow = 0, o_readBank = 0, o_writeBank = 1
  - o_swapPending = 0 (state READY), o_dropCount = 0
  - synced = 0; all counters 0
- Reset mid-frame: o_inWindow stays 0 until the first FS after reset. Pixels before that FS are blanked.
- o_readAddr latency: 1 cycle after the i_x/i_y it corresponds to.
- o_inWindow is `win` delayed by 2 cycles (address register plus 1-cycle synchronous SRAM read). The display mux gates SRAM data with it directly.
- The swap at FS is registered. `bankBase` takes its new value for the address computed in the cycle after FS. The first window pixel is at least Y_OFFSET lines later.
- Last window address, bank 1: 23040+23039 = 46079. Counters never exceed SRC_W-1 or SRC_H-1 by construction.

## Test plan
- Reset, then run one full frame with no i_frameDone:
  - o_readBank stays 0.
  - At (x=320,y=72) o_readAddr=0 one cycle later.
  - At (324,72) o_readAddr=1.
  - At (959,72) o_readAddr=159.
  - At (320,76) o_readAddr=160.
  - At (959,647) o_readAddr=23039.
  - o_inWindow rises 2 cycles after (320,72).
- Pulse i_frameDone mid-frame:
  - o_swapPending=1 until the next FS.
  - Then o_readBank=1 and o_writeBank=0.
  - First window address is 23040.
- Pulse i_frameDone twice before FS: o_dropCount=1, exactly one swap at FS.
- i_frameDone coincident with FS in READY: swap at that FS, o_swapPending never asserts.
- Assert i_resetN=0 for 1 cycle at (500,300):
  - o_inWindow=0 for the rest of that frame.
  - Correct addressing from the next FS.
  - Banks are back at 0/1.
- Hold i_active=0 inside the window coordinates:
  - o_inWindow=0.
  - o_readAddr=bankBase.
  - Column counters do not advance.
